// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel rising/falling edge detection with pending-event
// bits, sticky overrun flags and a round-robin arbiter feeding a single
// valid/ready event port backed by one output register.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] sig_in,
    input  logic [N_CH-1:0] rise_en,
    input  logic [N_CH-1:0] fall_en,
    output logic            event_valid,
    input  logic            event_ready,
    output logic [CH_W-1:0] event_chan,
    output logic            event_rising,
    output logic [N_CH-1:0] overrun,
    input  logic [N_CH-1:0] overrun_clr
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    // (a + k) mod N_CH for a < N_CH and 0 <= k < N_CH
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N_CH) s = s - N_CH;
        return PW'(s);
    endfunction

    logic [N_CH-1:0] d0_q, d1_q;
    logic [N_CH-1:0] rise_pend_q, rise_pend_d;
    logic [N_CH-1:0] fall_pend_q, fall_pend_d;
    logic [N_CH-1:0] overrun_q, overrun_d;
    logic            valid_q, valid_d;
    logic [CH_W-1:0] chan_q, chan_d;
    logic            rising_q, rising_d;
    logic [PW-1:0]   rr_q, rr_d;

    logic [N_CH-1:0] rise_ev, fall_ev, any_pend;
    logic [N_CH-1:0] clr_rise, clr_fall;
    logic            load, found, sel_rise;
    logic [PW-1:0]   sel;

    assign rise_ev  = d0_q & ~d1_q & rise_en;
    assign fall_ev  = ~d0_q & d1_q & fall_en;
    assign any_pend = rise_pend_q | fall_pend_q;
    assign load     = ~valid_q | event_ready;

    // Round-robin search for the first channel with anything pending, starting at rr_q
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && any_pend[wrap_add(rr_q, k)]) begin
                found = 1'b1;
                sel   = wrap_add(rr_q, k);
            end
        end
    end

    // Pick edge type on the granted channel; with both pending the older one goes first.
    // Edges alternate, so a high level means the falling edge is the older of the two.
    always_comb begin
        sel_rise = rise_pend_q[sel];
        if (rise_pend_q[sel] && fall_pend_q[sel]) sel_rise = ~d0_q[sel];
        clr_rise = '0;
        clr_fall = '0;
        if (load && found) begin
            if (sel_rise) clr_rise[sel] = 1'b1;
            else          clr_fall[sel] = 1'b1;
        end
    end

    // Pending and overrun next state; a new edge re-sets a bit being loaded this cycle
    always_comb begin
        rise_pend_d = (rise_pend_q & ~clr_rise) | rise_ev;
        fall_pend_d = (fall_pend_q & ~clr_fall) | fall_ev;
        overrun_d   = (overrun_q & ~overrun_clr)
                    | (rise_ev & rise_pend_q & ~clr_rise)
                    | (fall_ev & fall_pend_q & ~clr_fall);
    end

    // Output register next state: refill whenever empty or being accepted
    always_comb begin
        valid_d  = valid_q;
        chan_d   = chan_q;
        rising_d = rising_q;
        rr_d     = rr_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                chan_d   = CH_W'(sel);
                rising_d = sel_rise;
                rr_d     = wrap_add(sel, 1);
            end
        end
    end

    // State registers; reset preloads the edge detector with the live level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d0_q        <= sig_in;
            d1_q        <= sig_in;
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            overrun_q   <= '0;
            valid_q     <= 1'b0;
            chan_q      <= '0;
            rising_q    <= 1'b0;
            rr_q        <= '0;
        end else begin
            d0_q        <= sig_in;
            d1_q        <= d0_q;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            overrun_q   <= overrun_d;
            valid_q     <= valid_d;
            chan_q      <= chan_d;
            rising_q    <= rising_d;
            rr_q        <= rr_d;
        end
    end

    assign event_valid  = valid_q;
    assign event_chan   = chan_q;
    assign event_rising = rising_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios followed by random traffic.
// A reference model predicts each presented event into a queue; a monitor pops
// and compares whenever the DUT hands an event over.
module tb_edge_event_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] sig_in, rise_en, fall_en, overrun, overrun_clr;
    logic         event_valid, event_ready, event_rising;
    logic [1:0]   event_chan;

    int total = 0;
    int bad   = 0;

    typedef struct {int chan; bit rising;} ev_t;
    ev_t exp_q[$];

    // reference model state
    bit m_lv_now[N], m_lv_prev[N];
    bit m_rp[N], m_fp[N], m_ov[N];
    bit m_v;
    int m_chan, m_rr;
    bit m_rising;

    edge_event_arbiter #(.N_CH(N), .CH_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .rise_en(rise_en),
        .fall_en(fall_en), .event_valid(event_valid), .event_ready(event_ready),
        .event_chan(event_chan), .event_rising(event_rising),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_ov_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_ov[i];
        return v;
    endfunction

    // Reference model: events are pending per channel and type; each time the output
    // slot frees up, the next event is taken from the first busy channel at or after
    // the round-robin pointer.
    initial begin : model
        bit r, f, found;
        int c;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                for (int i = 0; i < N; i++) begin
                    m_lv_now[i] = sig_in[i];
                    m_lv_prev[i] = sig_in[i];
                    m_rp[i] = 0; m_fp[i] = 0; m_ov[i] = 0;
                end
                m_v = 0; m_chan = 0; m_rising = 0; m_rr = 0;
                exp_q.delete();
            end else begin
                if (!m_v || event_ready) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        c = (m_rr + k) % N;
                        if (!found && (m_rp[c] || m_fp[c])) begin
                            found = 1;
                            m_chan = c;
                            if (m_rp[c] && m_fp[c]) m_rising = !m_lv_now[c];
                            else                    m_rising = m_rp[c];
                            if (m_rising) m_rp[c] = 0; else m_fp[c] = 0;
                            m_rr = (c + 1) % N;
                        end
                    end
                    m_v = found;
                    if (found) exp_q.push_back('{chan: m_chan, rising: m_rising});
                end
                for (int i = 0; i < N; i++) begin
                    r = m_lv_now[i] && !m_lv_prev[i] && rise_en[i];
                    f = !m_lv_now[i] && m_lv_prev[i] && fall_en[i];
                    if (overrun_clr[i]) m_ov[i] = 0;
                    if (r) begin if (m_rp[i]) m_ov[i] = 1; m_rp[i] = 1; end
                    if (f) begin if (m_fp[i]) m_ov[i] = 1; m_fp[i] = 1; end
                end
                for (int i = 0; i < N; i++) begin
                    m_lv_prev[i] = m_lv_now[i];
                    m_lv_now[i] = sig_in[i];
                end
            end
        end
    end

    // Monitor: compare on the falling edge, pop on every handshake
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            chk("valid", 32'(event_valid), 32'(m_v));
            chk("overrun", 32'(overrun), 32'(m_ov_vec()));
            if (event_valid === 1'b1 && event_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(event_chan), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_chan", 32'(event_chan), 32'(e.chan));
                    chk("ev_rising", 32'(event_rising), 32'(e.rising));
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [N-1:0] lvl);
        reset_n = 1'b0;
        sig_in  = lvl;
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; sig_in = '0; rise_en = '0; fall_en = '0;
        event_ready = 1'b0; overrun_clr = '0;

        // 1: reset with inputs high on some channels -> no spurious events
        rise_en = 4'hF; fall_en = 4'hF;
        do_reset(4'b1010);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_no_event", 32'(event_valid), 32'd0);
        end

        // 2: single rising edge on ch2, two-cycle latency
        fall_en = 4'h0; event_ready = 1'b1;
        sig_in = 4'b1110;
        step(); chk("t2_lat_k", 32'(event_valid), 32'd0);
        step(); chk("t2_lat_k1", 32'(event_valid), 32'd0);
        step();
        chk("t2_valid", 32'(event_valid), 32'd1);
        chk("t2_chan", 32'(event_chan), 32'd2);
        chk("t2_rising", 32'(event_rising), 32'd1);
        step(); chk("t2_gone", 32'(event_valid), 32'd0);

        // 3: simultaneous rises on ch0,1,3 then round-robin drain; then ch0+ch1 again
        do_reset(4'b0000);
        event_ready = 1'b0; rise_en = 4'hF; fall_en = 4'h0;
        sig_in = 4'b1011;
        step(4);
        chk("t3_first", 32'(event_chan), 32'd0);
        event_ready = 1'b1;
        step(5);
        sig_in = 4'b0000; step(3);
        sig_in = 4'b0011; step(6);

        // 4: ch1 rise, fall, rise while output is stalled -> overrun on ch1, then clear
        do_reset(4'b0000);
        event_ready = 1'b0; rise_en = 4'hF; fall_en = 4'hF;
        sig_in = 4'b0001; step(3);
        sig_in = 4'b0011; step(2);
        sig_in = 4'b0001; step(2);
        chk("t4_no_ovr", 32'(overrun), 32'd0);
        sig_in = 4'b0011; step(2);
        chk("t4_ovr", 32'(overrun), 32'b0010);
        overrun_clr = 4'b0010; step();
        overrun_clr = 4'b0000;
        chk("t4_ovr_clr", 32'(overrun), 32'd0);
        event_ready = 1'b1; step(6);

        // 5: stalled output stays stable, then accept with more ch2 activity
        do_reset(4'b0000);
        event_ready = 1'b0;
        sig_in = 4'b0100; step(3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_v", 32'(event_valid), 32'd1);
            chk("t5_hold_c", 32'(event_chan), 32'd2);
            chk("t5_hold_r", 32'(event_rising), 32'd1);
        end
        sig_in = 4'b0000; step(2);
        event_ready = 1'b1; sig_in = 4'b0100; step(6);

        // 6: reset with events pending and presented discards everything
        event_ready = 1'b0;
        sig_in = 4'b0000; step(3);
        sig_in = 4'b0111; step(4);
        chk("t6_pre_valid", 32'(event_valid), 32'd1);
        do_reset(4'b0111);
        event_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6_cleared", 32'(event_valid), 32'd0);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            sig_in      = sig_in ^ (4'($urandom) & 4'($urandom));
            event_ready = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 19) == 0) rise_en = 4'($urandom);
            if ($urandom_range(0, 19) == 0) fall_en = 4'($urandom);
            reset_n = ($urandom_range(0, 299) != 0);
            step();
        end

        // drain
        reset_n = 1'b1; event_ready = 1'b1; overrun_clr = '0;
        step(20);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(event_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
